// File: rtl/sdp_bram_if.sv
// Port bundle for the simple dual-port line RAM: write port A, read port B,
// and the output-register enable. Clock and reset stay outside the bundle.
interface sdp_bram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  cea;
  logic [ADDR_WIDTH-1:0] ada;
  logic [DATA_WIDTH-1:0] din;
  logic                  ceb;
  logic [ADDR_WIDTH-1:0] adb;
  logic                  oce;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output cea, ada, din, ceb, adb, oce,
    input  dout
  );

  modport slave (
    input  cea, ada, din, ceb, adb, oce,
    output dout
  );
endinterface

// File: rtl/sdp_bram.sv
// Simple dual-port block RAM holding one image line: synchronous write port A,
// registered read port B with read-before-write on collision, optional output register.
module sdp_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 640,
  parameter int OUT_REG    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  sdp_bram_if.slave   bus
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_r;
  logic                  wr_ok_s;
  logic                  rd_ok_s;

  // Widened compare so DEPTH == 2**ADDR_WIDTH still works.
  assign wr_ok_s = ({1'b0, bus.ada} < (ADDR_WIDTH+1)'(DEPTH));
  assign rd_ok_s = ({1'b0, bus.adb} < (ADDR_WIDTH+1)'(DEPTH));

  // Memory array write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (bus.cea && wr_ok_s) begin
      mem_r[bus.ada] <= bus.din;
    end
  end

  // Read register; nonblocking update yields old data on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= {DATA_WIDTH{1'b0}};
    end else if (bus.ceb) begin
      rd_r <= rd_ok_s ? mem_r[bus.adb] : {DATA_WIDTH{1'b0}};
    end else begin
      rd_r <= rd_r;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_r;

      // Second pipeline stage, advanced only when oce is high.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_r <= {DATA_WIDTH{1'b0}};
        end else if (bus.oce) begin
          out_r <= rd_r;
        end else begin
          out_r <= out_r;
        end
      end

      assign bus.dout = out_r;
    end else begin : g_no_out_reg
      assign bus.dout = rd_r;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_bram.sv
// Self-checking bench for sdp_bram: one OUT_REG=0 and one OUT_REG=1 instance
// driven identically and compared against an array-based line memory model.
module tb_sdp_bram;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 640;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp0;      // expected dout, single read register
  logic [DW-1:0] exp1;      // expected dout, with output register
  logic [DW-1:0] rd_m;      // model of the first stage for the OUT_REG=1 copy

  sdp_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  sdp_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  sdp_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  sdp_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs to both copies, advance one edge, update the model.
  task automatic step(input logic cea, input int ada, input logic [DW-1:0] din,
                      input logic ceb, input int adb, input logic oce);
    logic [DW-1:0] nrd;
    logic [DW-1:0] nout;
    b0.cea = cea; b0.ada = AW'(ada); b0.din = din;
    b0.ceb = ceb; b0.adb = AW'(adb); b0.oce = oce;
    b1.cea = cea; b1.ada = AW'(ada); b1.din = din;
    b1.ceb = ceb; b1.adb = AW'(adb); b1.oce = oce;
    nrd  = ceb ? ((adb < DEPTH) ? model[adb] : 8'h00) : rd_m;
    nout = oce ? rd_m : exp1;
    if (cea && (ada < DEPTH)) model[ada] = din;
    @(posedge clk);
    #1;
    rd_m = nrd;
    exp0 = nrd;
    exp1 = nout;
  endtask

  task automatic test_reset_initial();
    #1;
    checks++;
    if (b0.dout !== 8'h00) begin
      errors++; $display("FAIL reset_init0: dout=%h expected=%h", b0.dout, 8'h00);
    end
    checks++;
    if (b1.dout !== 8'h00) begin
      errors++; $display("FAIL reset_init1: dout=%h expected=%h", b1.dout, 8'h00);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill_and_read();
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 8'(i), 1'b0, 0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, 8'h00, 1'b1, i, 1'b1);
      checks++;
      if (b0.dout !== 8'(i) || b0.dout !== exp0) begin
        errors++; $display("FAIL seq_read a=%0d: dout=%h expected=%h", i, b0.dout, 8'(i));
      end
      if (i > 0) begin
        checks++;
        if (b1.dout !== 8'(i - 1)) begin
          errors++; $display("FAIL seq_read_oreg a=%0d: dout=%h expected=%h", i, b1.dout, 8'(i - 1));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 5, 8'hAA, 1'b0, 0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b1, 5, 1'b1);
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b0.dout !== 8'h00) begin
      errors++; $display("FAIL reset_async0: dout=%h expected=%h", b0.dout, 8'h00);
    end
    checks++;
    if (b1.dout !== 8'h00) begin
      errors++; $display("FAIL reset_async1: dout=%h expected=%h", b1.dout, 8'h00);
    end
    rd_m = 8'h00; exp0 = 8'h00; exp1 = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 0, 8'h00, 1'b1, 5, 1'b1);
    checks++;
    if (b0.dout !== 8'hAA) begin
      errors++; $display("FAIL reset_persist: dout=%h expected=%h", b0.dout, 8'hAA);
    end
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    checks++;
    if (b1.dout !== 8'hAA) begin
      errors++; $display("FAIL reset_persist_oreg: dout=%h expected=%h", b1.dout, 8'hAA);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 10, 8'h11, 1'b0, 0, 1'b1);
    step(1'b1, 10, 8'h22, 1'b1, 10, 1'b1);
    checks++;
    if (b0.dout !== 8'h11) begin
      errors++; $display("FAIL collision_old: dout=%h expected=%h", b0.dout, 8'h11);
    end
    step(1'b0, 0, 8'h00, 1'b1, 10, 1'b1);
    checks++;
    if (b0.dout !== 8'h22) begin
      errors++; $display("FAIL collision_new: dout=%h expected=%h", b0.dout, 8'h22);
    end
  endtask

  task automatic test_enables();
    logic [DW-1:0] held;
    logic [DW-1:0] prior;
    step(1'b0, 0, 8'h00, 1'b1, 4, 1'b1);
    held = model[4];
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 8'h00, 1'b0, 100 + i, 1'b1);
      checks++;
      if (b0.dout !== held) begin
        errors++; $display("FAIL ceb_hold %0d: dout=%h expected=%h", i, b0.dout, held);
      end
    end
    prior = model[3];
    step(1'b0, 3, 8'hFF, 1'b0, 0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b1, 3, 1'b1);
    checks++;
    if (b0.dout !== prior) begin
      errors++; $display("FAIL cea_off: dout=%h expected=%h", b0.dout, prior);
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] m60;
    m60 = model[60];
    step(1'b1, 700, 8'h55, 1'b0, 0, 1'b1);
    step(1'b0, 0, 8'h00, 1'b1, 700, 1'b1);
    checks++;
    if (b0.dout !== 8'h00) begin
      errors++; $display("FAIL oor_read: dout=%h expected=%h", b0.dout, 8'h00);
    end
    step(1'b0, 0, 8'h00, 1'b1, 60, 1'b1);
    checks++;
    if (b0.dout !== m60) begin
      errors++; $display("FAIL oor_alias: dout=%h expected=%h", b0.dout, m60);
    end
  endtask

  task automatic test_out_reg();
    step(1'b1, 7, 8'h77, 1'b0, 0, 1'b1);
    step(1'b1, 8, 8'h88, 1'b1, 7, 1'b1);
    step(1'b0, 0, 8'h00, 1'b1, 8, 1'b1);
    checks++;
    if (b1.dout !== 8'h77) begin
      errors++; $display("FAIL oreg_latency: dout=%h expected=%h", b1.dout, 8'h77);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
      checks++;
      if (b1.dout !== 8'h77) begin
        errors++; $display("FAIL oreg_hold %0d: dout=%h expected=%h", i, b1.dout, 8'h77);
      end
    end
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    checks++;
    if (b1.dout !== 8'h88) begin
      errors++; $display("FAIL oreg_release: dout=%h expected=%h", b1.dout, 8'h88);
    end
  endtask

  task automatic test_random();
    int ada;
    int adb;
    for (int n = 0; n < 400; n++) begin
      ada = int'($urandom_range(0, 703));
      adb = ($urandom_range(0, 3) == 0) ? ada : int'($urandom_range(0, 703));
      step(1'($urandom_range(0, 1)), ada, 8'($urandom), 1'($urandom_range(0, 1)),
           adb, 1'($urandom_range(0, 3) != 0));
      checks++;
      if (b0.dout !== exp0) begin
        errors++; $display("FAIL rand0 n=%0d: dout=%h expected=%h", n, b0.dout, exp0);
      end
      checks++;
      if (b1.dout !== exp1) begin
        errors++; $display("FAIL rand1 n=%0d: dout=%h expected=%h", n, b1.dout, exp1);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    rd_m = 8'h00; exp0 = 8'h00; exp1 = 8'h00;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    b0.cea = 1'b0; b0.ada = '0; b0.din = '0; b0.ceb = 1'b0; b0.adb = '0; b0.oce = 1'b0;
    b1.cea = 1'b0; b1.ada = '0; b1.din = '0; b1.ceb = 1'b0; b1.adb = '0; b1.oce = 1'b0;
    test_reset_initial();
    test_fill_and_read();
    test_reset_midstream();
    test_collision();
    test_enables();
    test_out_of_range();
    test_out_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
